// File: rtl/keypad_scan_pkg.sv
// rtl/keypad_scan_pkg.sv - shared constants and helpers for the keypad scanner
// Optional build macro used by the top: KEYPAD_STICKY_CODE_EN.
package keypad_scan_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int CODE_W   = 4;

  localparam logic [3:0] COL_IDLE = 4'b1111;

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_PRESSED  = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  // Lowest-index low row wins when several rows are pulled low together.
  function automatic logic [1:0] lowest_low_row(input logic [NUM_ROWS-1:0] rows);
    lowest_low_row = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!rows[i]) lowest_low_row = 2'(i);
    end
  endfunction

endpackage

// File: rtl/keypad_sync2.sv
// rtl/keypad_sync2.sv - two-flop synchroniser for the asynchronous keypad rows
// Resets to all-high so an idle keypad is seen during and after reset.
module keypad_sync2
  import keypad_scan_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_ROWS-1:0] d_i,
  output logic [NUM_ROWS-1:0] q_o
);

  logic [NUM_ROWS-1:0] meta_q;
  logic [NUM_ROWS-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q <= COL_IDLE;
      sync_q <= COL_IDLE;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan_decoder.sv
// rtl/keypad_scan_decoder.sv - 4x4 keypad column scanner with press/release debounce
// KEYPAD_STICKY_CODE_EN keeps the last key code visible after release.
module keypad_scan_decoder
  import keypad_scan_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_ROWS-1:0] row_in,
  output logic [NUM_COLS-1:0] col_out,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_valid,
  output logic                key_event
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DB_W  = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_DONE  = DB_W'(DEBOUNCE_CNT);

  logic [NUM_ROWS-1:0] rs;
  logic [1:0]          state_q, state_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [1:0]          col_idx_q, col_idx_d;
  logic [DB_W-1:0]     db_cnt_q, db_cnt_d, db_inc;
  logic [1:0]          cand_row_q, cand_row_d;
  logic [1:0]          cand_col_q, cand_col_d;
  logic                tick, accept, released;

  logic [NUM_COLS-1:0] col_out_q;
  logic [CODE_W-1:0]   key_code_q;
  logic                key_valid_q, key_event_q;

  keypad_sync2 u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (row_in),
    .q_o     (rs)
  );

  assign tick   = (div_cnt_q == DIV_LAST);
  assign db_inc = db_cnt_q + 1'b1;

  // accept/released mark the edges the output stage reacts to.
  always_comb begin
    state_d    = state_q;
    div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;
    col_idx_d  = col_idx_q;
    db_cnt_d   = db_cnt_q;
    cand_row_d = cand_row_q;
    cand_col_d = cand_col_q;
    accept     = 1'b0;
    released   = 1'b0;
    if (tick) begin
      case (state_q)
        ST_SCAN: begin
          if (rs != COL_IDLE) begin
            cand_row_d = lowest_low_row(rs);
            cand_col_d = col_idx_q;
            db_cnt_d   = DB_W'(1);
            if (DEBOUNCE_CNT == 1) begin
              state_d = ST_PRESSED;
              accept  = 1'b1;
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (!rs[cand_row_q]) begin
            db_cnt_d = db_inc;
            if (db_inc == DB_DONE) begin
              state_d = ST_PRESSED;
              accept  = 1'b1;
            end
          end else begin
            state_d   = ST_SCAN;
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        ST_PRESSED: begin
          if (rs[cand_row_q]) begin
            db_cnt_d = DB_W'(1);
            if (DEBOUNCE_CNT == 1) begin
              state_d   = ST_SCAN;
              released  = 1'b1;
              col_idx_d = col_idx_q + 2'd1;
            end else begin
              state_d = ST_RELEASE;
            end
          end
        end
        default: begin
          if (rs[cand_row_q]) begin
            db_cnt_d = db_inc;
            if (db_inc == DB_DONE) begin
              state_d   = ST_SCAN;
              released  = 1'b1;
              col_idx_d = col_idx_q + 2'd1;
            end
          end else begin
            state_d = ST_PRESSED;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_SCAN;
      div_cnt_q  <= '0;
      col_idx_q  <= 2'd0;
      db_cnt_q   <= '0;
      cand_row_q <= 2'd0;
      cand_col_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      col_idx_q  <= col_idx_d;
      db_cnt_q   <= db_cnt_d;
      cand_row_q <= cand_row_d;
      cand_col_q <= cand_col_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      col_out_q   <= 4'b1110;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_event_q <= 1'b0;
    end else begin
      col_out_q   <= COL_IDLE ^ (4'b0001 << col_idx_d);
      key_event_q <= accept;
      if (accept) begin
        key_valid_q <= 1'b1;
        key_code_q  <= {cand_row_d, cand_col_d};
      end else if (released) begin
        key_valid_q <= 1'b0;
`ifdef KEYPAD_STICKY_CODE_EN
        key_code_q  <= key_code_q;
`else
        key_code_q  <= '0;
`endif
      end
    end
  end

  assign col_out   = col_out_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_event = key_event_q;

endmodule

// File: tb/tb_keypad_scan_decoder.sv
// tb/tb_keypad_scan_decoder.sv - self-checking bench for keypad_scan_decoder
// Keypad matrix model plus key_event scoreboard; SCAN_DIV=4, DEBOUNCE_CNT=3.
module tb_keypad_scan_decoder;

  localparam int SD = 4;
  localparam int DB = 3;
  localparam int NV = 6;

  typedef struct {
    logic [15:0] keys;
    logic [3:0]  code;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_event;
  logic [15:0] keys = '0;

  int          checks = 0;
  int          errors = 0;
  int          p = 0;
  int          ev_cnt = 0;
  logic        prev_ev = 1'b0;
  logic [3:0]  exp_q[$];
  vec_t        vecs[NV];

  always #5 clk = ~clk;

  // Key (r,c) pulls row r low only while column c is strobed low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  keypad_scan_decoder #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_event (key_event)
  );

  always @(posedge clk) p <= reset_n ? p + 1 : 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] key(input int r, input int c);
    logic [15:0] k;
    k = '0;
    k[r*4+c] = 1'b1;
    return k;
  endfunction

  always @(posedge clk) begin
    #1;
    if (reset_n) begin
      if (key_event) begin
        ev_cnt++;
        check("event_single_pulse", prev_ev, 0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got code %0h expected no event", key_code);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          check("event_code", key_code, e);
          check("event_valid", key_valid, 1);
        end
      end
      prev_ev = key_event;
    end else begin
      prev_ev = 1'b0;
    end
  end

  task automatic tick_align();
    do @(negedge clk); while (p % SD != 0);
  endtask

  task automatic wait_col(input logic [3:0] c);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick_align();
      if (col_out == c) found = 1'b1;
    end
    check("wait_col_seen", found, 1);
  endtask

  task automatic wait_event(input int n0, output int lat);
    lat = 0;
    while (ev_cnt == n0 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("event_seen", ev_cnt > n0, 1);
  endtask

  task automatic wait_release();
    for (int i = 0; i < 100 && key_valid; i++) @(negedge clk);
    check("release_seen", key_valid, 0);
  endtask

  function automatic logic [3:0] rel_code(input logic [3:0] c);
`ifdef KEYPAD_STICKY_CODE_EN
    return c;
`else
    return 4'h0;
`endif
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int n0;
    logic [3:0] ec;

    vecs[0] = '{key(0,0), 4'h0};
    vecs[1] = '{key(3,3), 4'hF};
    vecs[2] = '{key(2,1), 4'h9};
    vecs[3] = '{key(1,0) | key(2,0), 4'h4};
    vecs[4] = '{key(0,3) | key(1,3) | key(3,3), 4'h3};
    vecs[5] = '{key(3,2) | key(2,2), 4'hA};

    repeat (3) @(negedge clk);
    check("rst_col_out", col_out, 4'b1110);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_code", key_code, 0);
    check("rst_key_event", key_event, 0);
    reset_n = 1'b1;

    // Idle column walk, one column per SD clocks.
    for (int j = 0; j < 20; j++) begin
      ec = 4'hF;
      ec[(j / SD) % 4] = 1'b0;
      check("walk_col_out", col_out, ec);
      check("walk_key_valid", key_valid, 0);
      @(negedge clk);
    end

    // Press (1,2): exact latency, frozen column.
    wait_col(4'b1011);
    keys = key(1,2);
    exp_q.push_back(4'h6);
    wait_event(ev_cnt, lat);
    check("press_latency", lat, 12);
    check("press_valid", key_valid, 1);
    check("press_code", key_code, 4'h6);
    check("press_col_frozen", col_out, 4'b1011);
    @(negedge clk);
    check("press_event_drop", key_event, 0);

    // Release glitch, with unrelated keys changing meanwhile.
    tick_align();
    n0 = ev_cnt;
    keys = key(0,0);
    tick_align();
    check("glitch_valid_held", key_valid, 1);
    keys = key(1,2) | key(3,2) | key(0,0);
    repeat (4) tick_align();
    check("glitch_valid", key_valid, 1);
    check("glitch_code", key_code, 4'h6);
    check("glitch_no_event", ev_cnt, n0);
    check("glitch_col_frozen", col_out, 4'b1011);

    // Full release after DB high samples.
    keys = '0;
    repeat (11) @(negedge clk);
    check("release_valid_before", key_valid, 1);
    @(negedge clk);
    check("release_valid", key_valid, 0);
    check("release_code", key_code, rel_code(4'h6));
    check("release_col_next", col_out, 4'b0111);

    // Single-sample bounce on (1,2).
    wait_col(4'b1011);
    n0 = ev_cnt;
    keys = key(1,2);
    tick_align();
    check("bounce_col_frozen", col_out, 4'b1011);
    keys = '0;
    tick_align();
    check("bounce_col_resume", col_out, 4'b0111);
    check("bounce_valid", key_valid, 0);
    repeat (4) tick_align();
    check("bounce_no_event", ev_cnt, n0);

    // Two rows on col1, then reset while pressed.
    keys = key(0,1) | key(3,1);
    exp_q.push_back(4'h1);
    wait_event(ev_cnt, lat);
    check("multi_code", key_code, 4'h1);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("rstmid_valid", key_valid, 0);
    check("rstmid_col_out", col_out, 4'b1110);
    check("rstmid_event", key_event, 0);
    check("rstmid_code", key_code, 0);
    keys = '0;
    @(negedge clk);
    reset_n = 1'b1;

    for (int v = 0; v < NV; v++) begin
      keys = vecs[v].keys;
      exp_q.push_back(vecs[v].code);
      wait_event(ev_cnt, lat);
      check("vec_valid", key_valid, 1);
      check("vec_code", key_code, vecs[v].code);
      keys = '0;
      wait_release();
      check("vec_release_code", key_code, rel_code(vecs[v].code));
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    check("event_count", ev_cnt, 2 + NV);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
